inout_bus_master: RTL and testbench

//  Owns the far end of the shared 8-bit half-duplex tri-state bus whose peer drives sum onto the bus when its out_en=0.

---
 rtl/inout_bus_master_pkg.sv | 25 ++
 rtl/inout_bus_master_if.sv | 23 ++
 rtl/inout_bus_master_rsp_fifo.sv | 46 ++++
 rtl/inout_bus_master.sv | 124 ++++++++++++
 tb/tb_inout_bus_master.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inout_bus_master_pkg.sv
// Shared types and sizing helpers for the inout bus master.
package inout_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_TURN,
    W_DRIVE,
    W_REL,
    R_WAIT
  } ibm_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width large enough for the longest phase load value, plus one spare bit.
  function automatic int cnt_width(input int turn, input int hold, input int smp);
    return $clog2(max3(turn, hold, smp)) + 1;
  endfunction

  localparam int CNT_W = cnt_width(1, 4, 2);

endpackage

// File: rtl/inout_bus_master_if.sv
// Request/response handshake bundle between a client and the inout bus master.
interface inout_bus_master_if #(
  parameter int W = 8
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [W-1:0] req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         busy;

  modport master (
    input  req_valid, req_write, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    output req_valid, req_write, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/inout_bus_master_rsp_fifo.sv
// First-word fall-through synchronous FIFO holding captured read data.
module ibm_rsp_fifo #(
  parameter int W         = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(RSP_DEPTH);

  logic [W-1:0] mem [RSP_DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; data path carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/inout_bus_master.sv
// Master side of a shared half-duplex tri-state bus: sequences turnaround,
// drives write data, samples peer data for reads into a response FIFO.
module inout_bus_master
  import inout_bus_pkg::*;
#(
  parameter int W           = 8,
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_CYCLES = 4,
  parameter int SAMPLE_DLY  = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [W-1:0]        bus_io,
  output logic                bus_en,
  inout_bus_master_if.master  ifc
);
  localparam int CW = cnt_width(TURN_CYCLES, HOLD_CYCLES, SAMPLE_DLY);

  ibm_state_t   state;
  logic [CW-1:0] cnt;
  logic         drive_en;
  logic [W-1:0] wr_q;
  logic         accept;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;

  // Reads are only accepted with FIFO space reserved; reset holds off new requests.
  assign ifc.req_ready = !reset && (state == IDLE) && !fifo_full;
  assign accept        = ifc.req_valid && ifc.req_ready;
  assign ifc.busy      = (state != IDLE);
  assign fifo_push     = (state == R_WAIT) && (cnt == '0);
  assign fifo_pop      = ifc.rsp_valid && ifc.rsp_ready;
  assign ifc.rsp_valid = !fifo_empty;

  // Only drive once the peer has been told to release for the turnaround window.
  assign bus_io = drive_en ? wr_q : {W{1'bz}};

  // Bus ownership FSM with a single phase down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus_en   <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (ifc.req_write) begin
              state  <= W_TURN;
              bus_en <= 1'b1;
              cnt    <= CW'(TURN_CYCLES - 1);
            end else begin
              state <= R_WAIT;
              cnt   <= CW'(SAMPLE_DLY - 1);
            end
          end
        end
        W_TURN: begin
          if (cnt == '0) begin
            state    <= W_DRIVE;
            drive_en <= 1'b1;
            cnt      <= CW'(HOLD_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_DRIVE: begin
          if (cnt == '0) begin
            state    <= W_REL;
            drive_en <= 1'b0;
            cnt      <= CW'(TURN_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_REL: begin
          if (cnt == '0) begin
            state  <= IDLE;
            bus_en <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus_en   <= 1'b0;
          drive_en <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

  // Write data register, loaded on write accept.
  always_ff @(posedge clk) begin
    if (accept && ifc.req_write) wr_q <= ifc.req_data;
  end

  ibm_rsp_fifo #(
    .W         (W),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus_io),
    .pop       (fifo_pop),
    .pop_data  (ifc.rsp_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_inout_bus_master.sv
// Bench for inout_bus_master: models the bus peer and checks timing, data and FIFO order.
module tb_inout_bus_master;
  localparam int W = 8;
  localparam int T = 1;
  localparam int H = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] peer_val;
  wire  [W-1:0] bus_io;
  logic         bus_en;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Peer drives the bus whenever it is not told to release it.
  assign bus_io = bus_en ? {W{1'bz}} : peer_val;

  inout_bus_master_if #(.W(W)) ifc ();

  inout_bus_master #(
    .W(W), .TURN_CYCLES(T), .HOLD_CYCLES(H), .SAMPLE_DLY(S), .RSP_DEPTH(D)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus_io),
    .bus_en (bus_en),
    .ifc    (ifc)
  );

  // Whenever the peer owns the bus, the bus must show exactly the peer value.
  always begin
    @(negedge clk);
    #1;
    if (bus_en === 1'b0) begin
      n_tests++;
      if (bus_io !== peer_val) begin
        n_fail++;
        $display("FAIL contention: bus_io=%h peer_val=%h with bus_en=0", bus_io, peer_val);
      end
    end
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 50; i++) begin
      if (ifc.req_ready === 1'b1) break;
      @(negedge clk);
    end
    n_tests++;
    if (ifc.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_timeout: req_ready=%b expected 1 within 50 cycles", ifc.req_ready);
    end
  endtask

  task automatic do_write(input logic [W-1:0] d);
    wait_ready();
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b1;
    ifc.req_data  = d;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    ifc.req_data  = W'($urandom);
    for (int k = 1; k <= 2*T + H; k++) begin
      n_tests++;
      if (bus_en !== 1'b1) begin n_fail++; $display("FAIL wr_bus_en: cycle %0d got %b expected 1", k, bus_en); end
      n_tests++;
      if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: cycle %0d got %b expected 1", k, ifc.busy); end
      if (k > T && k <= T + H) begin
        n_tests++;
        if (bus_io !== d) begin n_fail++; $display("FAIL wr_drive: cycle %0d bus_io=%h expected %h", k, bus_io, d); end
      end else begin
        n_tests++;
        if (bus_io === d) begin n_fail++; $display("FAIL wr_dead: cycle %0d bus_io=%h expected released (not %h)", k, bus_io, d); end
      end
      @(negedge clk);
    end
    n_tests++;
    if (bus_en !== 1'b0) begin n_fail++; $display("FAIL wr_end_bus_en: got %b expected 0", bus_en); end
    n_tests++;
    if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL wr_end_busy: got %b expected 0", ifc.busy); end
  endtask

  task automatic do_read(input logic [W-1:0] pv, input bit pop_cap);
    bit popped;
    popped = 1'b0;
    wait_ready();
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b0;
    peer_val      = ~pv;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    n_tests++;
    if (bus_en !== 1'b0) begin n_fail++; $display("FAIL rd_bus_en: got %b expected 0", bus_en); end
    n_tests++;
    if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy1: got %b expected 1", ifc.busy); end
    n_tests++;
    if (ifc.rsp_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rd_valid1: got %b expected %b", ifc.rsp_valid, exp_q.size() != 0); end
    @(negedge clk);
    n_tests++;
    if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy2: got %b expected 1", ifc.busy); end
    n_tests++;
    if (ifc.rsp_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rd_valid2: got %b expected %b", ifc.rsp_valid, exp_q.size() != 0); end
    peer_val = pv;
    if (pop_cap) begin
      if (exp_q.size() != 0) begin
        n_tests++;
        if (ifc.rsp_data !== exp_q[0]) begin n_fail++; $display("FAIL rd_pop_head: got %h expected %h", ifc.rsp_data, exp_q[0]); end
        popped = 1'b1;
      end
      ifc.rsp_ready = 1'b1;
    end
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    if (popped) void'(exp_q.pop_front());
    exp_q.push_back(pv);
    peer_val = W'($urandom);
    n_tests++;
    if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy3: got %b expected 0", ifc.busy); end
    n_tests++;
    if (ifc.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid3: got %b expected 1", ifc.rsp_valid); end
    n_tests++;
    if (ifc.rsp_data !== exp_q[0]) begin n_fail++; $display("FAIL rd_head: got %h expected %h", ifc.rsp_data, exp_q[0]); end
  endtask

  task automatic pop_one();
    if (exp_q.size() == 0) begin
      n_tests++;
      if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty_valid: got %b expected 0", ifc.rsp_valid); end
    end else begin
      n_tests++;
      if (ifc.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL pop_valid: got %b expected 1", ifc.rsp_valid); end
      n_tests++;
      if (ifc.rsp_data !== exp_q[0]) begin n_fail++; $display("FAIL pop_data: got %h expected %h", ifc.rsp_data, exp_q[0]); end
      ifc.rsp_ready = 1'b1;
      @(negedge clk);
      ifc.rsp_ready = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic drain();
    while (exp_q.size() != 0) pop_one();
    n_tests++;
    if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", ifc.rsp_valid); end
  endtask

  function automatic logic [W-1:0] rand_wdata(input logic [W-1:0] avoid);
    logic [W-1:0] v;
    v = W'($urandom_range(1, 255));
    if (v == avoid) v = v ^ 8'h81;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus_en !== 1'b0) begin n_fail++; $display("FAIL rst_bus_en: got %b expected 0", bus_en); end
      n_tests++;
      if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", ifc.rsp_valid); end
      n_tests++;
      if (ifc.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", ifc.req_ready); end
      n_tests++;
      if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", ifc.busy); end
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (ifc.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", ifc.req_ready); end
    @(negedge clk);
  endtask

  task automatic test_write();
    do_write(8'hA5);
    do_write(rand_wdata(peer_val));
  endtask

  task automatic test_read();
    drain();
    do_read(8'h3C, 1'b0);
    drain();
  endtask

  task automatic test_fifo_full();
    drain();
    for (int i = 1; i <= 4; i++) do_read(W'(i), 1'b0);
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b0;
    peer_val      = 8'h05;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ifc.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_req_ready: got %b expected 0", ifc.req_ready); end
      @(negedge clk);
      n_tests++;
      if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL full_stall_busy: got %b expected 0", ifc.busy); end
    end
    ifc.req_valid = 1'b0;
    pop_one();
    do_read(8'h05, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      n_tests++;
      if (ifc.rsp_data !== W'(i)) begin n_fail++; $display("FAIL full_order: got %h expected %h", ifc.rsp_data, W'(i)); end
      pop_one();
    end
    drain();
  endtask

  task automatic test_reset_mid_write();
    logic [W-1:0] d;
    do_read(W'($urandom), 1'b0);
    d = rand_wdata(peer_val);
    wait_ready();
    ifc.req_valid = 1'b1;
    ifc.req_write = 1'b1;
    ifc.req_data  = d;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus_io !== d) begin n_fail++; $display("FAIL midrst_pre_drive: bus_io=%h expected %h", bus_io, d); end
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus_en !== 1'b0) begin n_fail++; $display("FAIL midrst_bus_en: got %b expected 0", bus_en); end
    n_tests++;
    if (bus_io !== peer_val) begin n_fail++; $display("FAIL midrst_bus_io: got %h expected peer %h", bus_io, peer_val); end
    @(negedge clk);
    n_tests++;
    if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo: rsp_valid=%b expected 0", ifc.rsp_valid); end
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_tests++;
    if (bus_en !== 1'b0) begin n_fail++; $display("FAIL midrst_after_bus_en: got %b expected 0", bus_en); end
    n_tests++;
    if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_after_busy: got %b expected 0", ifc.busy); end
    n_tests++;
    if (ifc.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_after_ready: got %b expected 1", ifc.req_ready); end
  endtask

  task automatic test_back_to_back();
    do_write(rand_wdata(peer_val));
    do_read(W'($urandom), 1'b1);
    do_write(rand_wdata(peer_val));
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(rand_wdata(peer_val));
      end else begin
        if (exp_q.size() == D) pop_one();
        do_read(W'($urandom), 1'($urandom_range(0, 1)));
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end
    drain();
  endtask

  initial begin
    ifc.req_valid = 1'b0;
    ifc.req_write = 1'b0;
    ifc.req_data  = '0;
    ifc.rsp_ready = 1'b0;
    peer_val      = 8'h5A;
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
